// File: rtl/oam_dma_pkg.sv
// Shared constants and state encoding for the sprite-attribute DMA engine.
package oam_dma_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DMA_REG_DEF  = 16'h4014;
  localparam logic [ADDR_W-1:0] OAM_PORT_DEF = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus seen by the DMA engine; master is the engine.
interface oam_dma_if;
  import oam_dma_pkg::*;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_o_data;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_i_data;
  logic              cpu_locked;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_o_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_i_data;

  modport master (
    input  cpu_address, cpu_o_data, cpu_we, mem_i_data,
    output cpu_i_data, cpu_locked, mem_address, mem_o_data, mem_we
  );
  modport slave (
    output cpu_address, cpu_o_data, cpu_we, mem_i_data,
    input  cpu_i_data, cpu_locked, mem_address, mem_o_data, mem_we
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: passes the cpu bus through in IDLE; on a write to DMA_REG it halts
// the cpu and copies one 256-byte page to OAM_PORT as read/write pairs.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG      = DMA_REG_DEF,
  parameter logic [ADDR_W-1:0] OAM_PORT     = OAM_PORT_DEF,
  parameter int                ALIGN_CYCLES = 1
) (
  input  logic      clock,
  input  logic      resetn,
  input  logic      locked,
  output logic      busy,
  oam_dma_if.master bus
);
  localparam logic [1:0] ALIGN_LAST = 2'(ALIGN_CYCLES - 1);

  state_t            state;
  logic [DATA_W-1:0] page;
  logic [DATA_W-1:0] cnt;
  logic [1:0]        align_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      page      <= '0;
      cnt       <= '0;
      align_cnt <= '0;
    end else if (locked) begin
      case (state)
        IDLE: if (bus.cpu_we && bus.cpu_address == DMA_REG) begin
          page      <= bus.cpu_o_data;
          cnt       <= '0;
          align_cnt <= '0;
          state     <= ALIGN;
        end
        ALIGN: begin
          if (align_cnt == ALIGN_LAST) state <= READ;
          else                         align_cnt <= align_cnt + 2'd1;
        end
        READ: state <= WRITE;
        WRITE: begin
          // 8-bit wrap keeps the source inside the page; cnt ends back at 0
          cnt   <= cnt + 8'd1;
          state <= (cnt == 8'hFF) ? DONE : READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign bus.cpu_locked = locked && (state == IDLE);
  assign bus.cpu_i_data = bus.mem_i_data;

  // Registered memory returns the READ byte during WRITE, so forward it directly
  always_comb begin
    bus.mem_address = bus.cpu_address;
    bus.mem_o_data  = bus.cpu_o_data;
    bus.mem_we      = 1'b0;
    case (state)
      IDLE:  bus.mem_we = bus.cpu_we;
      READ:  bus.mem_address = {page, cnt};
      WRITE: begin
        bus.mem_address = OAM_PORT;
        bus.mem_o_data  = bus.mem_i_data;
        bus.mem_we      = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a registered 64K memory model and bus monitor.
module tb_oam_dma;
  logic clock = 1'b0;
  logic resetn;
  logic locked;
  logic busy;
  int   checks = 0;
  int   fails  = 0;

  oam_dma_if bus();

  oam_dma dut (
    .clock  (clock),
    .resetn (resetn),
    .locked (locked),
    .busy   (busy),
    .bus    (bus.master)
  );

  always #20 clock = ~clock;

  logic [7:0]  mem [0:65535];
  logic [7:0]  wlog[$];
  logic [15:0] rlog[$];

  // Memory freezes with the rest of the system when locked is low
  always @(posedge clock) begin
    if (locked) begin
      if (bus.mem_we) mem[bus.mem_address] <= bus.mem_o_data;
      bus.mem_i_data <= mem[bus.mem_address];
    end
  end

  always @(posedge clock) begin
    if (resetn && locked) begin
      if (bus.mem_we && bus.mem_address == 16'h2004)
        wlog.push_back(bus.mem_o_data);
      else if (busy && !bus.mem_we && bus.mem_address != bus.cpu_address)
        rlog.push_back(bus.mem_address);
    end
  end

  // Trigger a copy of page pg; optionally drop locked for stall_len cycles once
  // stall_at bytes have been written. Returns the number of cpu-halted cycles.
  task automatic run_transfer(input logic [7:0] pg, input int stall_at,
                              input int stall_len, output int n);
    logic we0;
    logic [15:0] a0;
    int bad;
    bit stalled;
    wlog.delete();
    rlog.delete();
    @(negedge clock);
    bus.cpu_address = 16'h4014;
    bus.cpu_o_data  = pg;
    bus.cpu_we      = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.cpu_locked !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL trigger: cpu_locked=%b busy=%b, required 0 1", bus.cpu_locked, busy);
    end
    bus.cpu_we     = 1'b0;
    bus.cpu_o_data = 8'h00;
    n = 1;
    stalled = 0;
    while (n < 3000) begin
      if (stall_len > 0 && !stalled && wlog.size() == stall_at) begin
        stalled = 1;
        locked  = 1'b0;
        we0 = bus.mem_we;
        a0  = bus.mem_address;
        bad = 0;
        repeat (stall_len) begin
          @(posedge clock); #1;
          n++;
          if (bus.mem_we !== we0 || bus.mem_address !== a0 || dut.cnt !== 8'(stall_at)
              || wlog.size() != stall_at) bad++;
        end
        locked = 1'b1;
        checks++;
        if (bad != 0) begin
          fails++;
          $display("FAIL stall_hold: %0d cycles changed (cnt=%h), required 0", bad, dut.cnt);
        end
      end
      @(posedge clock); #1;
      if (bus.cpu_locked) break;
      n++;
    end
  endtask

  task automatic check_copy(input string nm, input logic [7:0] pg, input logic [7:0] key);
    int bad = 0;
    int rbad = 0;
    checks++;
    if (wlog.size() != 256) begin
      fails++;
      $display("FAIL %s_wcount: got %0d writes, required 256", nm, wlog.size());
    end
    for (int i = 0; i < 256 && i < wlog.size(); i++)
      if (wlog[i] !== (8'(i) ^ key)) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_data: %0d wrong bytes (first=%h), required 0", nm, bad, wlog[0]);
    end
    for (int i = 0; i < 256 && i < rlog.size(); i++)
      if (rlog[i] !== {pg, 8'(i)}) rbad++;
    checks++;
    if (rlog.size() != 256 || rbad != 0) begin
      fails++;
      $display("FAIL %s_reads: %0d reads, %0d bad, required 256 reads 0 bad", nm, rlog.size(), rbad);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    locked = 1'b1;
    bus.cpu_address = 16'h0000;
    bus.cpu_o_data  = 8'h00;
    bus.cpu_we      = 1'b0;
    #5;
    checks++;
    if (busy !== 1'b0 || bus.cpu_locked !== 1'b1 || bus.mem_we !== 1'b0 ||
        dut.cnt !== 8'h00 || dut.page !== 8'h00) begin
      fails++;
      $display("FAIL reset: busy=%b cpu_locked=%b mem_we=%b cnt=%h page=%h, required 0 1 0 00 00",
               busy, bus.cpu_locked, bus.mem_we, dut.cnt, dut.page);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clock);
    bus.cpu_address = 16'h0300;
    bus.cpu_o_data  = 8'h5A;
    bus.cpu_we      = 1'b1;
    #1;
    checks++;
    if (bus.mem_address !== 16'h0300 || bus.mem_o_data !== 8'h5A || bus.mem_we !== 1'b1 ||
        bus.cpu_locked !== 1'b1) begin
      fails++;
      $display("FAIL passthrough: addr=%h data=%h we=%b cpu_locked=%b, required 0300 5a 1 1",
               bus.mem_address, bus.mem_o_data, bus.mem_we, bus.cpu_locked);
    end
    @(negedge clock);
    bus.cpu_we = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.cpu_i_data !== 8'h5A || busy !== 1'b0) begin
      fails++;
      $display("FAIL passthrough_read: cpu_i_data=%h busy=%b, required 5a 0", bus.cpu_i_data, busy);
    end
  endtask

  task automatic test_basic_dma;
    int n;
    run_transfer(8'h02, 0, 0, n);
    checks++;
    if (n != 514) begin
      fails++;
      $display("FAIL basic_stall: %0d cycles, required 514", n);
    end
    check_copy("basic", 8'h02, 8'hA5);
  endtask

  task automatic test_page_wrap;
    int n;
    run_transfer(8'hFF, 0, 0, n);
    checks++;
    if (n != 514 || dut.cnt !== 8'h00) begin
      fails++;
      $display("FAIL wrap_stall: %0d cycles cnt=%h, required 514 00", n, dut.cnt);
    end
    check_copy("wrap", 8'hFF, 8'h3C);
  endtask

  task automatic test_locked_stall;
    int n;
    run_transfer(8'h02, 8'h40, 10, n);
    checks++;
    if (n != 524) begin
      fails++;
      $display("FAIL stall_total: %0d cycles, required 524", n);
    end
    check_copy("stall", 8'h02, 8'hA5);
  endtask

  task automatic test_reset_mid;
    int n;
    int w0;
    wlog.delete();
    @(negedge clock);
    bus.cpu_address = 16'h4014;
    bus.cpu_o_data  = 8'h02;
    bus.cpu_we      = 1'b1;
    @(negedge clock);
    bus.cpu_we = 1'b0;
    n = 0;
    while (wlog.size() < 128 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (wlog.size() != 128) begin
      fails++;
      $display("FAIL midreset_reach: %0d writes, required 128", wlog.size());
    end
    @(negedge clock); #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_abort: mem_we=%b busy=%b, required 0 0", bus.mem_we, busy);
    end
    w0 = wlog.size();
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(posedge clock); #1;
    checks++;
    if (wlog.size() != w0 || busy !== 1'b0 || bus.cpu_locked !== 1'b1) begin
      fails++;
      $display("FAIL midreset_idle: writes %0d->%0d busy=%b cpu_locked=%b, required same 0 1",
               w0, wlog.size(), busy, bus.cpu_locked);
    end
    run_transfer(8'h02, 0, 0, n);
    checks++;
    if (n != 514) begin
      fails++;
      $display("FAIL midreset_retry: %0d cycles, required 514", n);
    end
    check_copy("retry", 8'h02, 8'hA5);
  endtask

  task automatic test_non_trigger;
    logic [15:0] addrs [4];
    logic        wes   [4];
    int          hits;
    addrs = '{16'h4013, 16'h4015, 16'h2004, 16'h4014};
    wes   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.cpu_address = addrs[i];
      bus.cpu_o_data  = 8'h07;
      bus.cpu_we      = wes[i];
      @(negedge clock);
      bus.cpu_we = 1'b0;
      hits = 0;
      repeat (3) begin
        @(posedge clock); #1;
        if (busy !== 1'b0 || bus.cpu_locked !== 1'b1) hits++;
      end
      checks++;
      if (hits != 0) begin
        fails++;
        $display("FAIL non_trigger_%h_we%0b: busy seen %0d cycles, required 0", addrs[i], wes[i], hits);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
    end
    test_reset();
    test_passthrough();
    test_basic_dma();
    test_page_wrap();
    test_locked_stall();
    test_reset_mid();
    test_non_trigger();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
